// File: rtl/parking_pkg.sv
// Shared definitions for the parking gate sequencer: arbiter state encoding,
// spot count and the exit-location width.
package parking_pkg;

  localparam int NUM_SPOTS = 4;
  localparam int LOC_W     = 2;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ISSUE_EXIT  = 3'd1,
    ST_ISSUE_ENTER = 3'd2,
    ST_WAIT_DOOR   = 3'd3,
    ST_COOLDOWN    = 3'd4
  } arb_state_e;

  function automatic logic [LOC_W-1:0] lowest_pending(input logic [NUM_SPOTS-1:0] req);
    logic [LOC_W-1:0] idx;
    idx = '0;
    for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
      if (req[i]) idx = LOC_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sensor_debouncer.sv
// Two-flop synchroniser followed by a counting debouncer; emits a registered
// one-cycle pulse on each rising edge of the debounced level.
module sensor_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_prev_q;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    rise_d = level_q & ~level_prev_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      rise_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= raw;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      rise_q       <= rise_d;
      cnt_q        <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/parking_gate_sequencer.sv
// Debounces the entry and per-spot exit sensors, queues requests and feeds
// them one at a time to the parking FSM, waiting for its door acknowledge.
module parking_gate_sequencer
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DOOR_TIMEOUT    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 entrySensor,
  input  logic [NUM_SPOTS-1:0] exitSensor,
  input  logic                 doorOpen,
  input  logic                 isFull,
  output logic                 enter,
  output logic                 exit,
  output logic [LOC_W-1:0]     exitLocation,
  output logic                 rejected,
  output logic                 busy,
  output logic [NUM_SPOTS-1:0] pendingExits
);

  localparam int TMO_W = (DOOR_TIMEOUT > 2) ? $clog2(DOOR_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DOOR_TIMEOUT - 1);

  logic                 entry_level, entry_rise;
  logic [NUM_SPOTS-1:0] exit_level, exit_rise;

  sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry_db (
    .clk   (clk),
    .reset (reset),
    .raw   (entrySensor),
    .level (entry_level),
    .rise  (entry_rise)
  );

  for (genvar i = 0; i < NUM_SPOTS; i++) begin : g_exit_db
    sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_db (
      .clk   (clk),
      .reset (reset),
      .raw   (exitSensor[i]),
      .level (exit_level[i]),
      .rise  (exit_rise[i])
    );
  end

  arb_state_e           state_q;
  logic                 enter_q, exit_q, rejected_q;
  logic [LOC_W-1:0]     loc_q;
  logic [LOC_W-1:0]     svc_idx_q;
  logic                 svc_entry_q;
  logic [TMO_W-1:0]     tmo_q;

  logic                 entry_pending_q, entry_pending_d;
  logic [NUM_SPOTS-1:0] pending_exits_q, pending_exits_d;
  logic [NUM_SPOTS-1:0] exit_set, exit_clr;
  logic                 entry_set, entry_clr;
  logic                 reject_now;

  // Set terms are OR-ed in after the clears so a fresh edge during service survives.
  always_comb begin
    exit_set   = exit_rise & exit_level;
    entry_set  = entry_rise & entry_level;
    exit_clr   = '0;
    entry_clr  = 1'b0;
    reject_now = (state_q == ST_IDLE) && (pending_exits_q == '0) &&
                 entry_pending_q && isFull;
    if (state_q == ST_WAIT_DOOR && doorOpen) begin
      if (svc_entry_q) entry_clr = 1'b1;
      else             exit_clr[svc_idx_q] = 1'b1;
    end
    if (reject_now) entry_clr = 1'b1;
    pending_exits_d = (pending_exits_q & ~exit_clr) | exit_set;
    entry_pending_d = (entry_pending_q & ~entry_clr) | entry_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_exits_q <= '0;
      entry_pending_q <= 1'b0;
    end else begin
      pending_exits_q <= pending_exits_d;
      entry_pending_q <= entry_pending_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      enter_q     <= 1'b0;
      exit_q      <= 1'b0;
      rejected_q  <= 1'b0;
      loc_q       <= '0;
      svc_idx_q   <= '0;
      svc_entry_q <= 1'b0;
      tmo_q       <= '0;
    end else begin
      enter_q    <= 1'b0;
      exit_q     <= 1'b0;
      rejected_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pending_exits_q != '0) begin
            state_q     <= ST_ISSUE_EXIT;
            exit_q      <= 1'b1;
            loc_q       <= lowest_pending(pending_exits_q);
            svc_idx_q   <= lowest_pending(pending_exits_q);
            svc_entry_q <= 1'b0;
          end else if (reject_now) begin
            rejected_q <= 1'b1;
          end else if (entry_pending_q) begin
            state_q     <= ST_ISSUE_ENTER;
            enter_q     <= 1'b1;
            svc_entry_q <= 1'b1;
          end
        end
        ST_ISSUE_EXIT, ST_ISSUE_ENTER: begin
          state_q <= ST_WAIT_DOOR;
          tmo_q   <= '0;
        end
        ST_WAIT_DOOR: begin
          if (doorOpen || tmo_q == TMO_LAST) begin
            state_q <= ST_COOLDOWN;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_COOLDOWN: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign enter        = enter_q;
  assign exit         = exit_q;
  assign exitLocation = loc_q;
  assign rejected     = rejected_q;
  assign busy         = (state_q != ST_IDLE);
  assign pendingExits = pending_exits_q;

endmodule

// File: tb/tb_parking_gate_sequencer.sv
// Scoreboard bench for parking_gate_sequencer: directed sensor scenarios push
// the strobes they should produce; a negedge monitor pops and compares them.
module tb_parking_gate_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       entrySensor;
  logic [3:0] exitSensor;
  logic       doorOpen;
  logic       isFull;
  logic       enter;
  logic       exit_strobe;
  logic [1:0] exitLocation;
  logic       rejected;
  logic       busy;
  logic [3:0] pendingExits;

  parking_gate_sequencer #(.DEBOUNCE_CYCLES(4), .DOOR_TIMEOUT(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .entrySensor  (entrySensor),
    .exitSensor   (exitSensor),
    .doorOpen     (doorOpen),
    .isFull       (isFull),
    .enter        (enter),
    .exit         (exit_strobe),
    .exitLocation (exitLocation),
    .rejected     (rejected),
    .busy         (busy),
    .pendingExits (pendingExits)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int K_EXIT   = 0;
  localparam int K_ENTER  = 1;
  localparam int K_REJECT = 2;

  typedef struct {
    int kind;
    int loc;
    int due;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic expect_strobe(input int kind, input int loc, input int due);
    exp_t e;
    e.kind = kind;
    e.loc  = loc;
    e.due  = due;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every strobe/reject against the head of the scoreboard.
  logic prev_strobe = 1'b0;
  int   act_kind;
  exp_t head;
  always @(negedge clk) begin
    if (reset) begin
      prev_strobe = 1'b0;
    end else begin
      if (enter || exit_strobe) begin
        check_output("enter_exit_exclusive", int'(enter && exit_strobe), 0);
        check_output("no_back_to_back", int'(prev_strobe), 0);
      end
      if (enter || exit_strobe || rejected) begin
        act_kind = exit_strobe ? K_EXIT : (enter ? K_ENTER : K_REJECT);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_strobe: got kind %0d loc %0d, expected none (cycle %0d)",
                   act_kind, exitLocation, cyc);
        end else begin
          head = exp_q.pop_front();
          check_output("strobe_kind", act_kind, head.kind);
          check_output("strobe_cycle", cyc, head.due);
          if (head.kind == K_EXIT) check_output("strobe_loc", int'(exitLocation), head.loc);
        end
      end
      prev_strobe = enter || exit_strobe;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  int c;
  int seen_busy;

  initial begin
    reset       = 1'b1;
    entrySensor = 1'b0;
    exitSensor  = 4'b0000;
    doorOpen    = 1'b1;
    isFull      = 1'b0;
    tick(2);
    check_output("reset_enter", int'(enter), 0);
    check_output("reset_exit", int'(exit_strobe), 0);
    check_output("reset_rejected", int'(rejected), 0);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_pending", int'(pendingExits), 0);
    check_output("reset_loc", int'(exitLocation), 0);
    reset = 1'b0;
    tick(3);

    $display("[TB] single exit, spot 1");
    c = cyc;
    exitSensor = 4'b0010;
    expect_strobe(K_EXIT, 1, c + 9);
    tick(10);
    exitSensor = 4'b0000;
    check_output("t1_wait_pending", int'(pendingExits), 4'b0010);
    check_output("t1_wait_busy", int'(busy), 1);
    tick(1);
    check_output("t1_cool_busy", int'(busy), 1);
    check_output("t1_cool_exit", int'(exit_strobe), 0);
    check_output("t1_cool_pending", int'(pendingExits), 0);
    tick(1);
    check_output("t1_idle_busy", int'(busy), 0);
    tick(15);

    $display("[TB] entry glitch");
    entrySensor = 1'b1;
    tick(2);
    entrySensor = 1'b0;
    seen_busy = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (busy) seen_busy = 1;
    end
    check_output("t2_glitch_busy", seen_busy, 0);

    $display("[TB] entry plus exits 0 and 3 together");
    c = cyc;
    entrySensor = 1'b1;
    exitSensor  = 4'b1001;
    expect_strobe(K_EXIT, 0, c + 9);
    expect_strobe(K_EXIT, 3, c + 13);
    expect_strobe(K_ENTER, 0, c + 17);
    tick(8);
    check_output("t3_pending", int'(pendingExits), 4'b1001);
    entrySensor = 1'b0;
    exitSensor  = 4'b0000;
    tick(12);
    check_output("t3_done_busy", int'(busy), 0);
    check_output("t3_done_pending", int'(pendingExits), 0);
    tick(15);

    $display("[TB] entry while full");
    isFull = 1'b1;
    c = cyc;
    entrySensor = 1'b1;
    expect_strobe(K_REJECT, 0, c + 9);
    tick(8);
    entrySensor = 1'b0;
    tick(4);
    isFull = 1'b0;
    seen_busy = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (busy) seen_busy = 1;
    end
    check_output("t4_no_service", seen_busy, 0);

    $display("[TB] door timeout and retry, spot 2");
    doorOpen = 1'b0;
    c = cyc;
    exitSensor = 4'b0100;
    expect_strobe(K_EXIT, 2, c + 9);
    expect_strobe(K_EXIT, 2, c + 20);
    tick(8);
    exitSensor = 4'b0000;
    tick(9);
    check_output("t5_last_wait_busy", int'(busy), 1);
    check_output("t5_last_wait_pending", int'(pendingExits), 4'b0100);
    tick(1);
    check_output("t5_cool_busy", int'(busy), 1);
    check_output("t5_cool_exit", int'(exit_strobe), 0);
    tick(1);
    check_output("t5_idle_busy", int'(busy), 0);
    check_output("t5_kept_pending", int'(pendingExits), 4'b0100);
    tick(3);
    doorOpen = 1'b1;
    tick(2);
    check_output("t5_acked_pending", int'(pendingExits), 0);
    check_output("t5_acked_busy", int'(busy), 0);
    tick(15);

    $display("[TB] reset during door wait");
    doorOpen = 1'b0;
    c = cyc;
    exitSensor = 4'b0011;
    expect_strobe(K_EXIT, 0, c + 9);
    tick(8);
    exitSensor = 4'b0000;
    tick(4);
    check_output("t6_pre_busy", int'(busy), 1);
    check_output("t6_pre_pending", int'(pendingExits), 4'b0011);
    reset = 1'b1;
    #1;
    check_output("t6_rst_busy", int'(busy), 0);
    check_output("t6_rst_pending", int'(pendingExits), 0);
    check_output("t6_rst_exit", int'(exit_strobe), 0);
    check_output("t6_rst_enter", int'(enter), 0);
    tick(2);
    reset    = 1'b0;
    doorOpen = 1'b1;
    seen_busy = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (busy) seen_busy = 1;
    end
    check_output("t6_post_busy", seen_busy, 0);
    check_output("t6_post_pending", int'(pendingExits), 0);

    check_output("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
